// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and defaults for the button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE_UP  = 2'd0,
    CNT_DOWN = 2'd1,
    HELD     = 2'd2,
    CNT_UP   = 2'd3
  } db_state_e;

  localparam int BTN_RUN   = 0;
  localparam int BTN_CLRLD = 1;

  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_CYCLES   = 25000000;

endpackage

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - one button: 2-flop synchroniser, debounce FSM, press pulse.
// Optional auto-repeat of the press pulse under BTN_AUTOREPEAT_EN.
module debounce_cell
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic              key_s1_q, key_s1_d;
  logic              key_s2_q, key_s2_d;
  logic              p_sync;
  db_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              pulse_q, pulse_d;
  logic              rep_fire;

  // Key flops reset to released so a held key must be re-debounced after reset.
  always_comb begin
    key_s1_d = key_n;
    key_s2_d = key_s1_q;
  end

  assign p_sync = ~key_s2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = rep_fire;
    case (state_q)
      IDLE_UP: begin
        if (p_sync) begin
          state_d = CNT_DOWN;
          cnt_d   = CNT_ONE;
        end
      end
      CNT_DOWN: begin
        if (!p_sync) begin
          state_d = IDLE_UP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!p_sync) begin
          state_d = CNT_UP;
          cnt_d   = CNT_ONE;
        end
      end
      CNT_UP: begin
        if (p_sync) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_UP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_UP;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == CNT_UP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      state_q  <= IDLE_UP;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_q, rep_d;

  // Runs only while staying in HELD; any exit (or re-entry) restarts the period.
  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if ((state_q == HELD) && p_sync) begin
      if (rep_q == REP_LAST) begin
        rep_fire = 1'b1;
      end else begin
        rep_d = rep_q + REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = |REPEAT_CYCLES;
  assign rep_fire      = 1'b0;
`endif

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise switches, debounce KEY buttons into levels and press pulses.
// Define BTN_AUTOREPEAT_EN to re-fire Btn_pulse while a button is held.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int SW_WIDTH        = 8,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NUM_BTN-1:0]  Key_n,
  input  logic [SW_WIDTH-1:0] Sw,
  output logic [NUM_BTN-1:0]  Btn_level,
  output logic [NUM_BTN-1:0]  Btn_pulse,
  output logic [SW_WIDTH-1:0] Sw_sync
);

  logic [SW_WIDTH-1:0] sw_s1_q, sw_s1_d;
  logic [SW_WIDTH-1:0] sw_s2_q, sw_s2_d;

  always_comb begin
    sw_s1_d = Sw;
    sw_s2_d = sw_s1_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
    end
  end

  assign Sw_sync = sw_s2_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_cell (
      .clk   (Clk),
      .rst_n (Reset),
      .key_n (Key_n[i]),
      .level (Btn_level[i]),
      .pulse (Btn_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner with a run-length reference model.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int R = 10;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] Key_n;
  logic [7:0] Sw;
  logic [1:0] Btn_level;
  logic [1:0] Btn_pulse;
  logic [7:0] Sw_sync;

  int vectors = 0;
  int miscompares = 0;

  button_conditioner #(
    .NUM_BTN         (2),
    .SW_WIDTH        (8),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_CYCLES   (R)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Key_n     (Key_n),
    .Sw        (Sw),
    .Btn_level (Btn_level),
    .Btn_pulse (Btn_pulse),
    .Sw_sync   (Sw_sync)
  );

  always #5 Clk = ~Clk;

  // Model: a level flips once D consecutive samples disagree with it.
  logic [11:0] expq[$];
  logic [1:0]  kq[$];
  logic [7:0]  swq[$];
  logic [1:0]  m_level, m_pulse;
  int          m_run[2];
  int          m_rep[2];
  int          cyc = 0;

  task automatic model_reset();
    kq      = '{2'b11, 2'b11};
    swq     = '{8'h00};
    m_level = 2'b00;
    m_pulse = 2'b00;
    for (int b = 0; b < 2; b++) begin
      m_run[b] = 0;
      m_rep[b] = 0;
    end
  endtask

  task automatic model_step();
    logic [1:0] ks;
    logic [7:0] msw;
    logic       s;
    logic       held;
    if (!Reset) begin
      model_reset();
      msw = 8'h00;
    end else begin
      ks = kq.pop_front();
      kq.push_back(Key_n);
      swq.push_back(Sw);
      msw = swq.pop_front();
      for (int b = 0; b < 2; b++) begin
        s    = ~ks[b];
        held = m_level[b] && (m_run[b] == 0);
        m_pulse[b] = 1'b0;
        if (s != m_level[b]) begin
          m_run[b]++;
          if (m_run[b] == D) begin
            m_level[b] = s;
            m_run[b]   = 0;
            m_pulse[b] = s;
          end
        end else begin
          m_run[b] = 0;
        end
`ifdef BTN_AUTOREPEAT_EN
        if (held && s) begin
          m_rep[b]++;
          if (m_rep[b] == R) begin
            m_pulse[b] = 1'b1;
            m_rep[b]   = 0;
          end
        end else begin
          m_rep[b] = 0;
        end
`else
        if (held && s) m_rep[b] = 0;
`endif
      end
    end
    expq.push_back({m_level, m_pulse, msw});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clk);
      model_step();
      cyc++;
    end
  end

  // Monitor: compare every registered output vector against the model.
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge Clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        vectors++;
        if ({Btn_level, Btn_pulse, Sw_sync} !== e) begin
          miscompares++;
          $display("FAIL scoreboard cycle %0d: got level=%b pulse=%b sw=%h, want level=%b pulse=%b sw=%h",
                   cyc, Btn_level, Btn_pulse, Sw_sync, e[11:10], e[9:8], e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] k, input logic [7:0] s, input logic r);
    @(negedge Clk);
    Key_n = k;
    Sw    = s;
    Reset = r;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] k;
    Reset = 1'b0;
    Key_n = 2'b11;
    Sw    = 8'h00;
    #1;
    check("reset_outputs", {Btn_level, Btn_pulse, Sw_sync}, 12'h000);
    repeat (2) step(2'b11, 8'h00, 1'b0);
    repeat (6) step(2'b11, 8'h00, 1'b1);

    // Clean press on Run with switches A5; level/pulse expected after edge 5.
    step(2'b10, 8'hA5, 1'b1);
    for (int e = 0; e <= 6; e++) begin
      @(posedge Clk);
      #1;
      if (e == 0) check("sw_sync_edge0", {4'h0, Sw_sync}, 12'h000);
      if (e == 1) check("sw_sync_edge1", {4'h0, Sw_sync}, 12'h0A5);
      if (e == 4) check("press_edge4", {8'h00, Btn_level, Btn_pulse}, 12'h000);
      if (e == 5) check("press_edge5", {8'h00, Btn_level, Btn_pulse}, 12'h005);
      if (e == 6) check("press_edge6", {8'h00, Btn_level, Btn_pulse}, 12'h004);
    end
    repeat (13) step(2'b10, 8'hA5, 1'b1);

    // Release, then bounce, then simultaneous press.
    repeat (10) step(2'b11, 8'hA5, 1'b1);
    step(2'b10, 8'h3C, 1'b1);
    step(2'b11, 8'h3C, 1'b1);
    step(2'b10, 8'h3C, 1'b1);
    step(2'b11, 8'h3C, 1'b1);
    repeat (10) step(2'b10, 8'h3C, 1'b1);
    repeat (10) step(2'b11, 8'h3C, 1'b1);
    repeat (10) step(2'b00, 8'h5A, 1'b1);
    repeat (10) step(2'b11, 8'h5A, 1'b1);

    // Hold ClearA_LoadB, then reset while Run is two samples into its count.
    repeat (10) step(2'b01, 8'hF0, 1'b1);
    repeat (4) step(2'b00, 8'hF0, 1'b1);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("async_reset", {Btn_level, Btn_pulse, Sw_sync}, 12'h000);
    repeat (2) step(2'b00, 8'hF0, 1'b0);
    repeat (12) step(2'b00, 8'hF0, 1'b1);
    repeat (10) step(2'b11, 8'hF0, 1'b1);

`ifdef BTN_AUTOREPEAT_EN
    repeat (40) step(2'b10, 8'h11, 1'b1);
    repeat (10) step(2'b11, 8'h11, 1'b1);
`endif

    // Random keys with bouncy toggles, random switches, rare resets.
    k = 2'b11;
    repeat (800) begin
      k[0] = k[0] ^ ($urandom_range(0, 4) == 0);
      k[1] = k[1] ^ ($urandom_range(0, 4) == 0);
      step(k, 8'($urandom), ($urandom_range(0, 199) != 0));
    end
    repeat (10) step(2'b11, 8'h00, 1'b1);
    repeat (3) @(posedge Clk);
    #3;
    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Input-conditioning stage directly upstream of the 8-bit multiplier datapath/control.
- Takes raw active-low DE2 KEY buttons and the 8 slide switches.
- Synchronises everything to Clk and debounces each button.
- Emits clean per-button levels plus one-cycle press pulses; these drive the multiplier's Run and ClearA_LoadB, and the synchronised switches drive S.

Parameters:
NUM_BTN, 2, number of conditioned buttons (index 0 = Run, 1 = ClearA_LoadB)
SW_WIDTH, 8, switch bus width (matches multiplier operand S)
DEBOUNCE_CYCLES, 250000, consecutive stable samples required to accept a change (5 ms at 50 MHz); legal range 2..2^20
REPEAT_CYCLES, 25000000, auto-repeat period while held (used only with the optional feature)

Ports:
Clk  in  1  system clock; every register is clocked on its rising edge
Reset  in  1  asynchronous, active-low reset (asserts immediately on 0; release is synchronous to Clk upstream)
Key_n  in  NUM_BTN  raw pushbuttons, active-low (0 = pressed), asynchronous
Sw  in  SW_WIDTH  raw slide switches, asynchronous
Btn_level  out  NUM_BTN  debounced button state, active-high (1 = held)
Btn_pulse  out  NUM_BTN  one-Clk-cycle strobe on each accepted press
Sw_sync  out  SW_WIDTH  switches after 2-flop synchroniser

Behaviour:
- Reset (Reset = 0, async) values:
  - Btn_level = 0, Btn_pulse = 0, Sw_sync = 0.
  - Key synchroniser flops = 1 (released); switch synchroniser flops = 0.
  - Debounce counters = 0; repeat counters = 0.
- Reset asserted mid-debounce discards all progress; the first edge after release restarts sampling from the released state.
- Synchroniser: two flops per bit, no logic between them. Key bits are inverted after stage 2, giving pressed = 1 (p_sync).
- Sw_sync latency: 2 edges.
- Per-button debounce FSM, states IDLE_UP, CNT_DOWN, HELD, CNT_UP:
  - IDLE_UP, p_sync = 1 -> CNT_DOWN, cnt = 1.
  - CNT_DOWN, p_sync = 1 and cnt = DEBOUNCE_CYCLES-1 -> HELD, cnt = 0; Btn_level = 1; Btn_pulse = 1 for exactly this cycle.
  - CNT_DOWN, p_sync = 1 otherwise -> cnt += 1.
  - CNT_DOWN, p_sync = 0 -> IDLE_UP, cnt = 0 (the bounce is rejected).
  - HELD/CNT_UP: mirror image of the above on release. Btn_level goes to 0 on acceptance; no pulse on release.
- Btn_level = 1 in HELD and CNT_UP, 0 otherwise.
- Latency: if Key_n is low before edge 0 and stays low, Btn_level and Btn_pulse rise after edge 1+DEBOUNCE_CYCLES.
- Counter width: clog2(DEBOUNCE_CYCLES). The counter saturates structurally because reaching DEBOUNCE_CYCLES-1 forces a state change, so it never wraps.
- Buttons are fully independent; simultaneous presses produce simultaneous pulses.
- Btn_pulse is registered: never more than one cycle high per accepted press, and never high during reset.

Optional Feature:
BTN_AUTOREPEAT_EN
- Defined: while a button is in HELD, a per-button repeat counter runs. Btn_pulse re-fires for one cycle every REPEAT_CYCLES cycles after the initial press pulse, starting REPEAT_CYCLES cycles after it. The counter clears on leaving HELD.
- Undefined: no repeat counter is synthesised and REPEAT_CYCLES is ignored; exactly one pulse per press.

Decomposition:
- Package btn_pkg:
  - debounce state enum (IDLE_UP, CNT_DOWN, HELD, CNT_UP);
  - index constants BTN_RUN = 0, BTN_CLRLD = 1;
  - default DEBOUNCE_CYCLES and REPEAT_CYCLES constants.
- Sub-module debounce_cell: one button's synchroniser, FSM, counter and optional repeat logic. Instantiated NUM_BTN times in a generate loop.
- The switch synchroniser stays in the top module.

Test Plan (DEBOUNCE_CYCLES = 4, REPEAT_CYCLES = 10):
- Clean press: Key_n[0] 1 -> 0 before edge 0, held 20 cycles -> Btn_level[0] rises after edge 5; Btn_pulse[0] high exactly that one cycle; Btn_level[1] stays 0.
- Bounce: Key_n[0] toggles 0,1,0,1 on successive edges, then holds 0 -> no level change during the toggling; single pulse once 4 consecutive pressed samples are accepted.
- Release: from HELD, Key_n[0] -> 1 -> Btn_level[0] falls 5 edges later; Btn_pulse[0] stays 0.
- Simultaneous press of both keys -> Btn_pulse = 2'b11 in the same cycle.
- Reset mid-count: Reset = 0 two cycles into CNT_DOWN -> outputs 0 immediately. After release with key still held, a full 4-sample debounce restarts before the pulse.
- Sw = 8'hA5 applied -> Sw_sync = 8'hA5 after 2 edges.
- With BTN_AUTOREPEAT_EN defined, hold 40 cycles -> pulses at press cycle P, then P+10, P+20, P+30.
